// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared definitions for the MEM-stage data access unit:
//               RV32 load/store funct3 codes, access FSM states, byte-enable
//               patterns and an access-size decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // RV32 funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-enable patterns before lane shifting
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    // funct3[1:0] carries the size; the reserved codes 011 and 11x fall
    // through to word size.
    function automatic size_t decode_size(input logic [2:0] func3);
        size_t size;
        case (func3[1:0])
            2'b00:   size = SIZE_BYTE;
            2'b01:   size = SIZE_HALF;
            default: size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_align_ext
// Description : Combinational load formatter. Selects the addressed byte or
//               halfword of a read word and sign- or zero-extends it.
// Ports       : rdata    in  32  word returned by the data bus
//               byte_off in  2   byte address low bits
//               func3    in  3   RV32 load funct3
//               result   out 32  extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_align_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    // funct3[2] distinguishes LBU/LHU from LB/LH
    assign w_unsigned = func3[2];

    always_comb begin
        w_byte = rdata[7:0];
        case (byte_off)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Halfword selection ignores byte_off[0]: odd halfword addresses are
    // aligned down.
    assign w_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (decode_size(func3))
            SIZE_BYTE: result = w_unsigned ? {24'd0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
            SIZE_HALF: result = w_unsigned ? {16'd0, w_half}
                                           : {{16{w_half[15]}}, w_half};
            default:   result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_access
// Description : MEM-stage access unit. Turns RV32 load/store requests into
//               word-aligned bus transactions with byte enables, stalls the
//               pipeline until completion, and returns extended load data.
//               Optional macro MEM_MISALIGN_CHECK_EN: when defined, misaligned
//               halfword/word accesses skip the bus and raise OUT_misaligned.
// Parameters  : TIMEOUT_CYCLES - REQ cycles without mem_ack before bus error
// Ports       : clk, reset (async, active-high)
//               IN_mem_read/IN_mem_write/IN_func3/IN_addr/IN_store_data
//                   - request from EX/MEM
//               OUT_load_data/OUT_busywait/OUT_bus_error/OUT_misaligned
//                   - result and status towards the pipeline
//               mem_req/mem_we/mem_addr/mem_wdata/mem_be - bus request
//               mem_rdata/mem_ack - bus response
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_access
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IN_mem_read,
    input  logic        IN_mem_write,
    input  logic [2:0]  IN_func3,
    input  logic [31:0] IN_addr,
    input  logic [31:0] IN_store_data,
    output logic [31:0] OUT_load_data,
    output logic        OUT_busywait,
    output logic        OUT_bus_error,
    output logic        OUT_misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_be;
    logic [2:0]         r_func3;
    logic [1:0]         r_byte_off;
    logic [31:0]        r_load_data;
    logic               r_bus_error;

    logic               w_req_any;
    logic               w_misaligned;
    logic               w_timeout;
    size_t              w_size;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load_fmt;

    assign w_req_any = IN_mem_read | IN_mem_write;
    assign w_size    = decode_size(IN_func3);
    assign w_timeout = (r_state == REQ) && !mem_ack
                       && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_misaligned;

    assign w_misaligned = ((w_size == SIZE_HALF) && IN_addr[0])
                       || ((w_size == SIZE_WORD) && (IN_addr[1:0] != 2'b00));

    // Pulses only in the DONE cycle that follows a rejected request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= (r_state == IDLE) && w_req_any && w_misaligned;
        end
    end

    assign OUT_misaligned = r_misaligned;
`else
    assign w_misaligned   = 1'b0;
    assign OUT_misaligned = 1'b0;
`endif

    // Store lanes: data is replicated across the word so the byte enables
    // alone pick the target lane. Writes win when read and write are both set.
    always_comb begin
        w_be    = BE_WORD;
        w_wdata = 32'd0;
        if (IN_mem_write) begin
            w_wdata = IN_store_data;
            case (w_size)
                SIZE_BYTE: begin
                    w_be    = BE_BYTE << IN_addr[1:0];
                    w_wdata = {4{IN_store_data[7:0]}};
                end
                SIZE_HALF: begin
                    w_be    = BE_HALF << {IN_addr[1], 1'b0};
                    w_wdata = {2{IN_store_data[15:0]}};
                end
                default: begin
                    w_be    = BE_WORD;
                    w_wdata = IN_store_data;
                end
            endcase
        end
    end

    load_align_ext u_load_align_ext (
        .rdata    (mem_rdata),
        .byte_off (r_byte_off),
        .func3    (r_func3),
        .result   (w_load_fmt)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_next_state = w_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            r_func3     <= 3'd0;
            r_byte_off  <= 2'd0;
            r_load_data <= 32'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    r_bus_error <= 1'b0;
                    if (w_req_any) begin
                        if (w_misaligned) begin
                            r_load_data <= 32'd0;
                        end else begin
                            r_mem_we    <= IN_mem_write;
                            r_mem_addr  <= {IN_addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_be    <= w_be;
                            r_func3     <= IN_func3;
                            r_byte_off  <= IN_addr[1:0];
                            // Counts the REQ cycle being entered
                            r_cnt       <= CNT_W'(1);
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still completes normally
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_load_data <= w_load_fmt;
                        end
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_load_data <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_bus_error <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    // Request strobe derives from the async-reset state register, so reset
    // withdraws it without waiting for a clock edge.
    assign mem_req       = (r_state == REQ);
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_be        = r_mem_be;
    assign OUT_load_data = r_load_data;
    assign OUT_bus_error = r_bus_error;
    assign OUT_busywait  = !reset
                        && (((r_state == IDLE) && w_req_any) || (r_state == REQ));

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_access
// Description : Self-checking bench for data_mem_access with a reactive bus
//               memory, a behavioural access model and a scoreboard monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_access;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        IN_mem_read;
    logic        IN_mem_write;
    logic [2:0]  IN_func3;
    logic [31:0] IN_addr;
    logic [31:0] IN_store_data;
    logic [31:0] OUT_load_data;
    logic        OUT_busywait;
    logic        OUT_bus_error;
    logic        OUT_misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    data_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .IN_mem_read    (IN_mem_read),
        .IN_mem_write   (IN_mem_write),
        .IN_func3       (IN_func3),
        .IN_addr        (IN_addr),
        .IN_store_data  (IN_store_data),
        .OUT_load_data  (OUT_load_data),
        .OUT_busywait   (OUT_busywait),
        .OUT_bus_error  (OUT_bus_error),
        .OUT_misaligned (OUT_misaligned),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load_data;
        logic        bus_error;
        logic        misaligned;
        int          busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Memory behaviour for the current access
    int          mem_delay = 0;
    logic [31:0] mem_word  = 32'd0;
    logic        late_ack  = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: what the pipeline and bus should see for one access
    function automatic exp_t model(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] sdata, input logic [31:0] rdata,
                                   input int delay);
        exp_t        e;
        int          sz;
        int          off;
        logic [31:0] v;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(addr[1:0]);
`ifdef MEM_MISALIGN_CHECK_EN
        e.misaligned = (sz == 2 && addr[0]) || (sz == 4 && off != 0);
`else
        e.misaligned = 1'b0;
`endif
        e.we   = wr;
        e.addr = addr & 32'hFFFF_FFFC;
        e.be   = 4'hF;
        e.wdata = 32'd0;
        if (wr) begin
            if (sz == 1) begin
                e.be    = 4'(1 << off);
                e.wdata = {24'd0, sdata[7:0]} * 32'h0101_0101;
            end else if (sz == 2) begin
                e.be    = addr[1] ? 4'b1100 : 4'b0011;
                e.wdata = {16'd0, sdata[15:0]} * 32'h0001_0001;
            end else begin
                e.wdata = sdata;
            end
        end
        if (sz == 1) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        e.bus_error = !e.misaligned && (delay >= TO);
        e.load_data = (e.misaligned || e.bus_error) ? 32'd0 : v;
        e.busy      = e.misaligned ? 1 : 1 + ((delay >= TO) ? TO : delay + 1);
        if (!rd && !wr) e.busy = 0;
        return e;
    endfunction

    // Reactive bus memory: acks after mem_delay REQ cycles, one-cycle pulse
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (late_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                late_ack  = 1'b0;
            end else if (mem_req && !reset) begin
                if (wait_cnt == mem_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: bus fields while requesting, results in DONE
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (mem_req) begin
                    if (q.size() == 0) begin
                        check("unexpected_req", 32'(mem_req), 32'd0);
                    end else begin
                        check("bus_we", 32'(mem_we), 32'(q[0].we));
                        check("bus_addr", mem_addr, q[0].addr);
                        check("bus_be", 32'(mem_be), 32'(q[0].be));
                        if (q[0].we) check("bus_wdata", mem_wdata, q[0].wdata);
                    end
                end
                if (prev_busy && !OUT_busywait) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'(OUT_busywait), 32'd1);
                    end else begin
                        e = q.pop_front();
                        check("bus_error", 32'(OUT_bus_error), 32'(e.bus_error));
                        check("misaligned", 32'(OUT_misaligned), 32'(e.misaligned));
                        if (!e.we || e.bus_error || e.misaligned)
                            check("load_data", OUT_load_data, e.load_data);
                    end
                end else if (OUT_bus_error || OUT_misaligned) begin
                    check("flag_outside_done",
                          32'({OUT_bus_error, OUT_misaligned}), 32'd0);
                end
                prev_busy = OUT_busywait;
            end
        end
    end

    // One pipeline access: present the request, hold it until the stall
    // releases, and confirm the number of stalled cycles.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int delay);
        exp_t e;
        int   busy;
        bit   saw_req;
        bit   ended;
        e = model(rd, wr, f3, addr, sdata, rdata, delay);
        q.push_back(e);
        mem_delay = delay;
        mem_word  = rdata;
        @(posedge clk);
        #1;
        IN_mem_read   = rd;
        IN_mem_write  = wr;
        IN_func3      = f3;
        IN_addr       = addr;
        IN_store_data = sdata;
        busy    = 0;
        saw_req = 0;
        ended   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) saw_req = 1;
            if (!OUT_busywait) begin
                ended = 1;
                break;
            end
            busy++;
        end
        if (!ended) begin
            n_checks++;
            n_err++;
            $display("FAIL stall_bound: busywait still high after 40 cycles");
        end
        check("busy_cycles", 32'(busy), 32'(e.busy));
        check("req_issued", 32'(saw_req), 32'(!e.misaligned));
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        IN_mem_read  = 1'b0;
        IN_mem_write = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        int unsigned kind;

        reset         = 1'b1;
        IN_mem_read   = 1'b0;
        IN_mem_write  = 1'b0;
        IN_func3      = 3'd0;
        IN_addr       = 32'd0;
        IN_store_data = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_load_data", OUT_load_data, 32'd0);
        check("rst_flags", 32'({OUT_bus_error, OUT_misaligned}), 32'd0);
        check("rst_busywait", 32'(OUT_busywait), 32'd0);
        #2 reset = 1'b0;

        // Directed cases
        do_access(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1);
        check("lw_value", OUT_load_data, 32'hDEAD_BEEF);
        do_access(1, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 0);
        check("lb_value", OUT_load_data, 32'hFFFF_FF80);
        do_access(1, 0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 2);
        check("lbu_value", OUT_load_data, 32'h0000_0080);
        do_access(0, 1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'd0, 0);
        do_access(1, 0, 3'b010, 32'h0000_0040, 32'd0, 32'h1111_2222, 6);
        check("timeout_load_zero", OUT_load_data, 32'd0);
        do_access(1, 0, 3'b101, 32'h0000_0042, 32'd0, 32'h9876_5432, 3);
        check("after_timeout_lhu", OUT_load_data, 32'h0000_9876);
        do_access(1, 1, 3'b000, 32'h0000_0081, 32'h0000_0055, 32'd0, 1);
`ifdef MEM_MISALIGN_CHECK_EN
        do_access(1, 0, 3'b010, 32'h0000_0102, 32'd0, 32'h0BAD_F00D, 0);
        check("misaligned_load_zero", OUT_load_data, 32'd0);
`endif

        // Reset during REQ, then a stray ack that must be ignored
        e = model(1, 0, 3'b010, 32'h0000_0300, 32'd0, 32'd0, 100);
        q.push_back(e);
        mem_delay = 100;
        @(posedge clk);
        #1;
        IN_mem_read  = 1'b1;
        IN_mem_write = 1'b0;
        IN_func3     = 3'b010;
        IN_addr      = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        check("req_before_reset", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("reset_drops_req", 32'(mem_req), 32'd0);
        check("reset_drops_busy", 32'(OUT_busywait), 32'd0);
        @(negedge clk);
        q.delete();
        IN_mem_read = 1'b0;
        #2 reset = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("late_ack_no_req", 32'(mem_req), 32'd0);
        check("late_ack_no_busy", 32'(OUT_busywait), 32'd0);
        idle(2);
        do_access(1, 0, 3'b001, 32'h0000_0302, 32'd0, 32'hC001_7E57, 0);
        check("after_reset_lh", OUT_load_data, 32'hFFFF_C001);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 7);
            if (kind == 7) begin
                idle($urandom_range(1, 3));
            end else begin
                wr = (kind < 3) || (kind == 6);
                rd = (kind >= 3);
                f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
                do_access(rd, wr, f3, $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 5)));
            end
        end
        idle(3);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
